mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the core's data-memory bus, alongside the data memory.
- The core writes bytes to a TXDATA register. The bytes are buffered in a small FIFO and serialised 8N1, LSB first, on `otx`.
- A STATUS register exposes FIFO and transmitter state for polling.
- `osel` tells the top level to mux this block's `ordata` instead of the data memory's read data, and to suppress the data-memory write.

---
 rtl/mmio_uart_tx_pkg.sv | 21 ++
 rtl/mmio_uart_tx_sync_fifo.sv | 67 ++++++
 rtl/mmio_uart_tx.sv | 171 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Register offsets, STATUS bit positions and TX FSM states.
package mmio_uart_tx_pkg;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;

    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_BUSY   = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_CNT_LO = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// First-word fall-through synchronous FIFO.
// Count carries one extra bit so full and empty never alias.
module sync_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          iclk,
    input  logic          irst,
    input  logic          iwr,
    input  logic [W-1:0]  iwdata,
    input  logic          ird,
    output logic [W-1:0]  ordata,
    output logic          ofull,
    output logic          oempty,
    output logic [AW:0]   ocount
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          wr_ok;
    logic          rd_ok;

    assign ofull  = (count_q == (AW+1)'(DEPTH));
    assign oempty = (count_q == '0);
    assign ocount = count_q;
    assign ordata = mem_q[rptr_q];

    // A full FIFO still accepts a write when a read frees a slot.
    assign rd_ok = ird & ~oempty;
    assign wr_ok = iwr & (~ofull | rd_ok);

    always_comb begin
        count_d = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge iclk) begin
        if (wr_ok) begin
            mem_q[wptr_q] <= iwdata;
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (rd_ok) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: TXDATA/STATUS registers, TX FIFO and 8N1 serialiser.
// otx is registered from the current FSM state, so it trails state by one cycle.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int          MP_DATA_WIDTH = 32,
    parameter logic [31:0] MP_BASE_ADDR  = 32'h1000_0000,
    parameter int          MP_CLK_DIV    = 868,
    parameter int          MP_FIFO_DEPTH = 8
) (
    input  logic                     iclk,
    input  logic                     irst,
    input  logic [31:0]              iaddr,
    input  logic                     iwen,
    input  logic [MP_DATA_WIDTH-1:0] iwdata,
    output logic [MP_DATA_WIDTH-1:0] ordata,
    output logic                     osel,
    output logic                     otx,
    output logic                     oirq
);

    localparam int          CW      = $clog2(MP_FIFO_DEPTH) + 1;
    localparam logic [15:0] TICK_AT = 16'(MP_CLK_DIV - 1);

    logic [3:0]    off;
    logic          push;
    logic          pop;
    logic [7:0]    f_data;
    logic          f_full;
    logic          f_empty;
    logic [CW-1:0] f_count;
    logic [7:0]    cnt8;
    logic [11:0]   status;
    logic          ovf_set;
    logic          ovf_clr;
    logic          tick;

    tx_state_e   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        ovf_q, ovf_d;

    assign off  = iaddr[3:0];
    assign osel = (iaddr[31:4] == MP_BASE_ADDR[31:4]);
    assign push = osel & iwen & (off == OFF_TXDATA);
    assign tick = (baud_q == TICK_AT);

    sync_fifo #(
        .W     (8),
        .DEPTH (MP_FIFO_DEPTH)
    ) u_fifo (
        .iclk   (iclk),
        .irst   (irst),
        .iwr    (push),
        .iwdata (iwdata[7:0]),
        .ird    (pop),
        .ordata (f_data),
        .ofull  (f_full),
        .oempty (f_empty),
        .ocount (f_count)
    );

    assign cnt8 = 8'(f_count);

    always_comb begin
        status               = '0;
        status[ST_FULL]      = f_full;
        status[ST_EMPTY]     = f_empty;
        status[ST_BUSY]      = (state_q != S_IDLE);
        status[ST_OVF]       = ovf_q;
        status[ST_CNT_LO+:4] = cnt8[3:0];
    end

    always_comb begin
        ordata = '0;
        if (osel && off == OFF_STATUS) begin
            ordata[11:0] = status;
        end
    end

    // A drop and a clear landing together leave overflow set.
    assign ovf_set = push & f_full & ~pop;
    assign ovf_clr = osel & iwen & (off == OFF_STATUS) & iwdata[ST_OVF];
    assign ovf_d   = ovf_set | (ovf_q & ~ovf_clr);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        if (state_q != S_IDLE) begin
            baud_d = tick ? '0 : baud_q + 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!f_empty) begin
                    pop     = 1'b1;
                    shift_d = f_data;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (!f_empty) begin
                        pop     = 1'b1;
                        shift_d = f_data;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            S_IDLE:  tx_d = 1'b1;
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_q[0];
            S_STOP:  tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign otx  = tx_q;
    assign oirq = f_empty & (state_q == S_IDLE);

    logic unused_ok;
    assign unused_ok = ^{iwdata[MP_DATA_WIDTH-1:8], cnt8[7:4]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised scoreboard bench for mmio_uart_tx with a frame-level model
// and a serial receiver that checks every emitted frame.
module tb_mmio_uart_tx;

    localparam int          DIV   = 4;
    localparam int          DEPTH = 8;
    localparam int          FRAME = 10 * DIV;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        irst;
    logic [31:0] iaddr;
    logic        iwen;
    logic [31:0] iwdata;
    logic [31:0] ordata;
    logic        osel;
    logic        otx;
    logic        oirq;

    mmio_uart_tx #(
        .MP_DATA_WIDTH (32),
        .MP_BASE_ADDR  (BASE),
        .MP_CLK_DIV    (DIV),
        .MP_FIFO_DEPTH (DEPTH)
    ) dut (
        .iclk   (clk),
        .irst   (irst),
        .iaddr  (iaddr),
        .iwen   (iwen),
        .iwdata (iwdata),
        .ordata (ordata),
        .osel   (osel),
        .otx    (otx),
        .oirq   (oirq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)",
                     name, act, exp, edge_n);
        end
    endtask

    // Reference model: bytes waiting in the FIFO, bytes already started
    // on the wire, and the edge at which the last frame began.
    typedef struct {
        logic [7:0] b;
        int         e;
    } exp_t;

    logic [7:0] mq[$];
    exp_t       sbq[$];
    int         edge_n   = 0;
    int         last_pop = 0;
    bit         have_pop = 0;
    bit         ovf_m    = 0;
    int         rst_edge = -1;

    function automatic bit in_win(input logic [31:0] a);
        return a[31:4] == BASE[31:4];
    endfunction

    function automatic bit busy_m();
        return have_pop && (edge_n < last_pop + FRAME);
    endfunction

    function automatic logic [31:0] status_m();
        logic [31:0] s;
        s        = '0;
        s[0]     = (mq.size() == DEPTH);
        s[1]     = (mq.size() == 0);
        s[2]     = busy_m();
        s[3]     = ovf_m;
        s[11:8]  = 4'(mq.size());
        return s;
    endfunction

    always @(posedge clk) begin
        edge_n++;
        if (irst) begin
            mq.delete();
            sbq.delete();
            ovf_m    = 0;
            have_pop = 0;
            rst_edge = edge_n;
        end else begin
            if (mq.size() > 0 &&
                (!have_pop || edge_n >= last_pop + FRAME)) begin
                sbq.push_back('{b: mq.pop_front(), e: edge_n});
                last_pop = edge_n;
                have_pop = 1;
            end
            if (in_win(iaddr) && iwen && iaddr[3:0] == 4'h4 && iwdata[3])
                ovf_m = 0;
            if (in_win(iaddr) && iwen && iaddr[3:0] == 4'h0) begin
                if (mq.size() < DEPTH) mq.push_back(iwdata[7:0]);
                else ovf_m = 1;
            end
        end
    end

    // Serial receiver: sample each bit mid-cell, compare against scoreboard.
    bit         rx_on = 0;
    bit         rx_has_exp;
    int         rx_start;
    int         rx_off;
    logic [9:0] rx_bits;

    always @(negedge clk) begin
        if (rst_edge == edge_n) begin
            rx_on = 0;
        end else if (!rx_on) begin
            if (otx === 1'b0) begin
                rx_on      = 1;
                rx_start   = edge_n;
                rx_has_exp = sbq.size() > 0;
                chk("frame_expected", 32'(rx_has_exp), 1);
                if (rx_has_exp)
                    chk("frame_start_edge", edge_n, sbq[0].e + 1);
            end
        end else begin
            rx_off = edge_n - rx_start;
            if (rx_off % DIV == DIV / 2) begin
                rx_bits[rx_off / DIV] = otx;
                if (rx_off / DIV == 9) begin
                    rx_on = 0;
                    chk("start_bit", 32'(rx_bits[0]), 0);
                    chk("stop_bit", 32'(rx_bits[9]), 1);
                    if (rx_has_exp) begin
                        chk("rx_byte", 32'(rx_bits[8:1]), 32'(sbq[0].b));
                        void'(sbq.pop_front());
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        iaddr  = a;
        iwdata = d;
        iwen   = 1'b1;
        @(negedge clk);
        iwen   = 1'b0;
        iaddr  = '0;
    endtask

    task automatic read_check(input string name, input logic [31:0] a);
        logic [31:0] exp;
        iaddr = a;
        #1;
        exp = (in_win(a) && a[3:0] == 4'h4) ? status_m() : 32'h0;
        chk({name, "_osel"}, 32'(osel), 32'(in_win(a)));
        chk({name, "_rdata"}, ordata, exp);
        chk({name, "_irq"}, 32'(oirq),
            32'(mq.size() == 0 && !busy_m()));
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (n < 3000 && (mq.size() != 0 || sbq.size() != 0 ||
               rx_on || busy_m())) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drained"}, 32'(n < 3000), 1);
    endtask

    logic [31:0] st;

    initial begin
        irst   = 1'b1;
        iaddr  = '0;
        iwen   = 1'b0;
        iwdata = '0;
        idle(2);
        irst = 1'b0;

        idle(50);
        chk("reset_otx", 32'(otx), 1);
        chk("reset_irq", 32'(oirq), 1);
        read_check("reset_status", BASE + 4);
        chk("reset_status_abs", ordata, 32'h2);

        bus_write(BASE, 32'hA5);
        chk("lat_w0", 32'(otx), 1);
        @(negedge clk);
        chk("lat_w1", 32'(otx), 1);
        @(negedge clk);
        chk("lat_w2", 32'(otx), 0);
        drain("single");
        read_check("after_single", BASE + 4);

        bus_write(BASE, 32'h01);
        bus_write(BASE, 32'h02);
        bus_write(BASE, 32'h03);
        read_check("burst_st0", BASE + 4);
        for (int i = 0; i < 3; i++) begin
            idle(FRAME);
            read_check("burst_st", BASE + 4);
        end
        drain("burst");

        for (int i = 0; i < 10; i++)
            bus_write(BASE, 32'h40 + 32'(i));
        read_check("ovf_st", BASE + 4);
        st = ordata;
        chk("ovf_full", 32'(st[0]), 1);
        chk("ovf_flag", 32'(st[3]), 1);
        bus_write(BASE + 4, 32'h8);
        read_check("ovf_clr_st", BASE + 4);
        st = ordata;
        chk("ovf_clr_flag", 32'(st[3]), 0);
        chk("ovf_clr_full", 32'(st[0]), 1);
        drain("ovf");

        bus_write(BASE, 32'h3C);
        idle(15);
        irst = 1'b1;
        @(negedge clk);
        irst = 1'b0;
        chk("midrst_otx", 32'(otx), 1);
        read_check("midrst_st", BASE + 4);
        chk("midrst_st_abs", ordata, 32'h2);
        idle(100);
        chk("midrst_quiet", 32'(otx), 1);

        bus_write(32'h0000_0010, 32'h55);
        read_check("outwin", 32'h0000_0010);
        read_check("outwin_st", BASE + 4);
        read_check("reg8", BASE + 8);
        read_check("regC", BASE + 12);

        for (int i = 0; i < 30; i++) begin
            bus_write(BASE + 32'($urandom_range(0, 1) * 4) *
                      ($urandom_range(0, 7) == 0 ? 1 : 0),
                      $urandom);
            if ($urandom_range(0, 3) == 0)
                read_check("rnd_st", BASE + 4);
            if ($urandom_range(0, 4) == 0)
                idle($urandom_range(10, 90));
            else
                idle($urandom_range(0, 3));
        end
        drain("random");
        read_check("final_st", BASE + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
